// File: rtl/mult_div_sequencer.sv
// HI/LO multiply/divide sequencer: WIDTH-iteration shift-add multiply or restoring
// divide, plus MTHI/MTLO/MFHI/MFLO access and a pipeline stall when busy.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       mult_func,
    input  logic             pause_in,
    output logic [WIDTH-1:0] c_out,
    output logic             pause_out,
    output logic             busy_out
);
    localparam logic [3:0] FUNC_NOTHING       = 4'd0;
    localparam logic [3:0] FUNC_READ_LO       = 4'd1;
    localparam logic [3:0] FUNC_READ_HI       = 4'd2;
    localparam logic [3:0] FUNC_WRITE_LO      = 4'd3;
    localparam logic [3:0] FUNC_WRITE_HI      = 4'd4;
    localparam logic [3:0] FUNC_MULT          = 4'd5;
    localparam logic [3:0] FUNC_SIGNED_MULT   = 4'd6;
    localparam logic [3:0] FUNC_DIVIDE        = 4'd7;
    localparam logic [3:0] FUNC_SIGNED_DIVIDE = 4'd8;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_next;
    logic [WIDTH-1:0]   opnd_q;
    logic               a_neg_q, b_neg_q, is_div_q;

    logic               cmd_present, accept, is_op, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    // Handshake: mult_func is a command held by the pipeline; it is taken at a rising
    // edge only when pause_in=0 and pause_out=0, otherwise the pipeline keeps it stable.
    assign cmd_present = (mult_func != FUNC_NOTHING) && (mult_func <= FUNC_SIGNED_DIVIDE);
    assign busy_out    = (state_q != ST_IDLE);
    assign pause_out   = busy_out && cmd_present;
    assign accept      = !pause_in && !pause_out;
    assign is_op       = (mult_func >= FUNC_MULT) && (mult_func <= FUNC_SIGNED_DIVIDE);
    assign op_signed   = (mult_func == FUNC_SIGNED_MULT) || (mult_func == FUNC_SIGNED_DIVIDE);
    assign op_div      = (mult_func == FUNC_DIVIDE) || (mult_func == FUNC_SIGNED_DIVIDE);
    assign a_neg       = op_signed && a_in[WIDTH-1];
    assign b_neg       = op_signed && b_in[WIDTH-1];
    assign a_mag       = a_neg ? (~a_in + 1'b1) : a_in;
    assign b_mag       = b_neg ? (~b_in + 1'b1) : b_in;

    always_comb begin
        c_out = '0;
        if (mult_func == FUNC_READ_LO) c_out = lo_q;
        else if (mult_func == FUNC_READ_HI) c_out = hi_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_op) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient}
    // for divide. A zero divisor needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend magnitude as remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div_q)
            acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
        else
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 1'b1) : acc_q;
        if (is_div_q) begin
            fix_lo = (a_neg_q ^ b_neg_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            fix_hi = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    if (mult_func == FUNC_WRITE_LO) lo_q <= a_in;
                    if (mult_func == FUNC_WRITE_HI) hi_q <= a_in;
                    if (is_op) begin
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        is_div_q <= op_div;
                        cnt_q    <= CNT_LAST;
                        opnd_q   <= op_div ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q - CNT_ONE;
                end
                ST_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multi-cycle controller and datapath for the HI/LO multiply/divide resource, driven by the decoder's 4-bit mult_func field.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO commands and sequences a WIDTH-iteration shift-add multiply or restoring divide.
- Owns the HI/LO registers.
- Stalls the pipeline through pause_out when a command arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; also the iteration count per operation

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
a_in  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b_in  input  WIDTH  rt operand (divisor / multiplier)
mult_func  input  4  command from decoder, `MULT_* encodings from defined.vh
pause_in  input  1  pipeline stalled by another source; no command accepted
c_out  output  WIDTH  read data for MFHI/MFLO, otherwise 0
pause_out  output  1  stall request to pipeline
busy_out  output  1  operation in flight

Behaviour:
- Encodings: NOTHING=0, READ_LO=1, READ_HI=2, WRITE_LO=3, WRITE_HI=4, MULT=5, SIGNED_MULT=6, DIVIDE=7, SIGNED_DIVIDE=8; values 9-15 are treated as NOTHING.
- Reset (rst=0, asynchronous): state=IDLE, HI=LO=0, counter=0, busy_out=0, pause_out=0, c_out=0. Reset mid-operation aborts the operation; HI and LO are cleared.
- pause_out (combinational) = busy_out & (mult_func != NOTHING).
- Acceptance: a command is accepted at a rising edge only when pause_in=0 and pause_out=0. When pause_in=1, no state changes except running iterations, which continue.
- c_out (combinational): LO when mult_func=READ_LO, HI when READ_HI, else 0. c_out is valid only when pause_out=0.
- WRITE_LO / WRITE_HI while idle: LO (or HI) <= a_in at the accepting edge; busy_out is not raised. A read in the next cycle returns the new value.
- States: IDLE -> RUN -> FIX -> IDLE.
  - IDLE -> RUN on an accepted MULT/SIGNED_MULT/DIVIDE/SIGNED_DIVIDE. Operand magnitudes, signs and the op type are latched; counter = WIDTH-1.
  - RUN: one iteration per edge. Counter decrements; at counter=0 the next state is FIX.
  - FIX: one cycle. Applies sign correction, writes HI/LO, then returns to IDLE.
- Timing: busy_out is 1 for exactly WIDTH+1 cycles after the accepting edge. HI/LO are updated at the FIX edge. A read issued immediately after the start is paused WIDTH+1 cycles, then returns the result.
- Magnitudes: signed ops use |a|, |b| as unsigned WIDTH-bit values, so 0x80000000 maps to 0x80000000; unsigned ops use the raw operands.
- Multiply: 2*WIDTH-bit shift-add product. The product is negated in FIX if the signs differ (signed op only). HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring, one quotient bit per iteration, producing quotient Q and remainder R.
  - Signed op: Q is negated if the signs differ; R takes the dividend's sign.
  - Result: LO = Q, HI = R.
- Divide by zero (no exception):
  - DIVU: LO = all ones, HI = a_in.
  - DIV: LO = 0xFFFFFFFF if a >= 0 else 0x00000001; HI = a_in.
- Commands received while busy:
  - Any non-NOTHING command raises pause_out and is held by the stalled pipeline. It is accepted at the first edge after FIX, when busy_out=0.
  - A new operation cannot start in the FIX cycle.
- Simultaneous events: pause_in=1 in the same cycle as a command means the command is not accepted. An active pause_in does not stop RUN/FIX progression.

Test Plan:
- Reset, then MULTU a=3 b=5; hold READ_LO the next cycle -> pause_out=1 for 33 cycles, then c_out=0x0000000F; READ_HI -> 0x00000000.
- SIGNED_MULT a=0xFFFFFFFE b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- SIGNED_DIVIDE a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVIDE a=100 b=7 -> LO=14, HI=2.
- DIVU a=0x1234 b=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV a=0xFFFFFFF0 b=0 -> LO=0x00000001, HI=0xFFFFFFF0.
- Idle WRITE_HI a=0xDEADBEEF, then READ_HI -> c_out=0xDEADBEEF with no pause. WRITE_LO issued mid-MULT -> paused until busy_out falls, then LO=a_in, overriding the product LO.
- Assert rst low at RUN iteration 10 -> busy_out=0, pause_out=0, HI=LO=0 immediately. pause_in=1 with a MULT present -> busy_out stays 0 until pause_in drops.
